// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, FSM states, matrix position lookup.
// KEYPAD_EMU_BOUNCE_EN adds the BOUNCE state to the emulator state enum.
package keypad_pkg;

    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd13;

`ifdef KEYPAD_EMU_BOUNCE_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_BOUNCE,
        ST_PRESS,
        ST_GAP
    } emu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_PRESS,
        ST_GAP
    } emu_state_t;
`endif

    typedef struct packed {
        logic       ok;
        logic [1:0] col;
        logic [1:0] row;
    } keypos_t;

    function automatic keypos_t key_pos(input logic [3:0] code);
        keypos_t p;
        p = '{ok: 1'b1, col: 2'd0, row: 2'd0};
        case (code)
            4'd1:     begin p.col = 2'd0; p.row = 2'd0; end
            4'd4:     begin p.col = 2'd0; p.row = 2'd1; end
            4'd7:     begin p.col = 2'd0; p.row = 2'd2; end
            KEY_STAR: begin p.col = 2'd0; p.row = 2'd3; end
            4'd2:     begin p.col = 2'd1; p.row = 2'd0; end
            4'd5:     begin p.col = 2'd1; p.row = 2'd1; end
            4'd8:     begin p.col = 2'd1; p.row = 2'd2; end
            4'd0:     begin p.col = 2'd1; p.row = 2'd3; end
            4'd3:     begin p.col = 2'd2; p.row = 2'd0; end
            4'd6:     begin p.col = 2'd2; p.row = 2'd1; end
            4'd9:     begin p.col = 2'd2; p.row = 2'd2; end
            KEY_HASH: begin p.col = 2'd2; p.row = 2'd3; end
            default:  p.ok = 1'b0;
        endcase
        return p;
    endfunction

    // Codes 12, 14 and 15 are not keys and not the blank press.
    function automatic logic key_is_err(input logic [3:0] code);
        return (code == 4'd12) || (code == 4'd14) || (code == 4'd15);
    endfunction

endpackage

// File: rtl/keypad_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded 8'hA5, steps every cycle.
// Used as the contact-chatter source for the keypad emulator.
module keypad_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 8'hA5;
        end else begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// 3x4 keypad stand-in answering scanner column strobes with row returns.
// Define KEYPAD_EMU_BOUNCE_EN for a one-frame chattering BOUNCE before PRESS.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_FRAMES = 2,
    parameter int GAP_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       col0,
    input  logic       col1,
    input  logic       col2,
    output logic       row0,
    output logic       row1,
    output logic       row2,
    output logic       row3,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] HOLD_N = HOLD_FRAMES[3:0];
    localparam logic [3:0] GAP_N  = GAP_FRAMES[3:0];

    emu_state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] code_q, code_n;
    logic       col2_d;
    logic       done_q, done_n;
    logic       err_q, err_n;
    logic       frame;
    logic       accept;
    logic       pressed;
    logic       col_hit;
    logic [3:0] cols;
    logic [3:0] rows;
    keypos_t    pos;

    assign frame  = col2_d & ~col2;
    assign accept = key_valid & key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            code_q <= KEY_NONE;
            col2_d <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            code_q <= code_n;
            col2_d <= col2;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (key_is_err(key_code)) begin
                        err_n = 1'b1;
                    end else begin
                        code_n  = key_code;
                        state_n = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (frame) begin
                    cnt_n = 4'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    state_n = ST_BOUNCE;
`else
                    state_n = ST_PRESS;
`endif
                end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            ST_BOUNCE: begin
                if (frame) begin
                    cnt_n   = 4'd0;
                    state_n = ST_PRESS;
                end
            end
`endif
            ST_PRESS: begin
                if (frame) begin
                    if (cnt + 4'd1 == HOLD_N) begin
                        cnt_n   = 4'd0;
                        state_n = ST_GAP;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (frame) begin
                    if (cnt + 4'd1 == GAP_N) begin
                        cnt_n   = 4'd0;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [7:0] lfsr;

    keypad_lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign pressed = (code_q != KEY_NONE) &
                     ((state == ST_PRESS) |
                      ((state == ST_BOUNCE) & lfsr[0]));
`else
    assign pressed = (code_q != KEY_NONE) & (state == ST_PRESS);
`endif

    // Rows are combinational on the strobes so the scanner sees them
    // in the very cycle it drives the column.
    assign pos     = key_pos(code_q);
    assign cols    = {1'b0, col2, col1, col0};
    assign col_hit = cols[pos.col];

    always_comb begin
        rows = 4'd0;
        if (pressed && pos.ok && col_hit) begin
            rows[pos.row] = 1'b1;
        end
    end

    assign row0 = rows[0];
    assign row1 = rows[1];
    assign row2 = rows[2];
    assign row3 = rows[3];

    // Hold off the next key for the done cycle so ready follows done.
    assign key_ready = (state == ST_IDLE) & ~done_q & ~rst;
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule
